// File: rtl/stopwatch_adjust_display.sv
// Stopwatch minute adjuster with BCD range saturation, plus a one-cycle
// registered display that substitutes an error code when an error is active.
module stopwatch_adjust_display #(
   parameter logic [15:0] MIN_TIME  = 16'h1020,
   parameter logic [15:0] MAX_TIME  = 16'h4930,
   parameter logic [15:0] ERR_CODE0 = 16'hEEEE,
   parameter logic [15:0] ERR_CODE1 = 16'h5555
) (
   input  logic        clk_in,
   input  logic        RESET,
   input  logic        ADD,
   input  logic        SUBTRACT,
   input  logic [15:0] PEV_Q,
   input  logic [15:0] Q,
   input  logic        ERROR_1,
   input  logic        ERROR_2,
   output logic [15:0] values_from_adder,
   output logic        signal,
   output logic        error_signal,
   output logic        error_index,
   output logic [15:0] D_Q
);

   logic [3:0]  tmin, mins, tsec, secs;
   logic        pev_invalid;

   logic [3:0]  inc_tmin, inc_mins;
   logic        inc_carry;
   logic [15:0] inc_val;
   logic        inc_over;

   logic [3:0]  dec_tmin, dec_mins;
   logic        dec_borrow;
   logic [15:0] dec_val;
   logic        dec_under;

   logic [15:0] d_q_q, d_q_d;

   assign tmin = PEV_Q[15:12];
   assign mins = PEV_Q[11:8];
   assign tsec = PEV_Q[7:4];
   assign secs = PEV_Q[3:0];

   assign pev_invalid = (tmin > 4'd9) | (mins > 4'd9) | (tsec > 4'd5) | (secs > 4'd9);

   // BCD increment of the minute field; carry out of tens-min means overflow.
   always_comb begin
      inc_carry = 1'b0;
      inc_tmin  = tmin;
      inc_mins  = mins + 4'd1;
      if (mins == 4'd9) begin
         inc_mins = 4'd0;
         if (tmin == 4'd9) begin
            inc_tmin  = 4'd0;
            inc_carry = 1'b1;
         end else begin
            inc_tmin = tmin + 4'd1;
         end
      end
   end

   assign inc_val  = {inc_tmin, inc_mins, tsec, secs};
   assign inc_over = inc_carry | (inc_val > MAX_TIME);

   // BCD decrement of the minute field; borrow out of tens-min means underflow.
   always_comb begin
      dec_borrow = 1'b0;
      dec_tmin   = tmin;
      dec_mins   = mins - 4'd1;
      if (mins == 4'd0) begin
         dec_mins = 4'd9;
         if (tmin == 4'd0) begin
            dec_tmin   = 4'd9;
            dec_borrow = 1'b1;
         end else begin
            dec_tmin = tmin - 4'd1;
         end
      end
   end

   assign dec_val   = {dec_tmin, dec_mins, tsec, secs};
   assign dec_under = dec_borrow | (dec_val < MIN_TIME);

   // Digits are valid BCD here, so a plain binary compare orders them as BCD.
   always_comb begin
      values_from_adder = PEV_Q;
      signal            = 1'b0;
      if (ADD != SUBTRACT) begin
         if (pev_invalid) begin
            values_from_adder = PEV_Q;
            signal            = 1'b1;
         end else if (ADD) begin
            if (inc_over) begin
               values_from_adder = MAX_TIME;
               signal            = 1'b1;
            end else begin
               values_from_adder = inc_val;
            end
         end else begin
            if (dec_under) begin
               values_from_adder = MIN_TIME;
               signal            = 1'b1;
            end else begin
               values_from_adder = dec_val;
            end
         end
      end
   end

   assign error_signal = ERROR_1 | ERROR_2;
   assign error_index  = ERROR_2 & ~ERROR_1;

   always_comb begin
      d_q_d = Q;
      if (error_signal) begin
         d_q_d = error_index ? ERR_CODE1 : ERR_CODE0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (RESET) begin
         d_q_q <= 16'h0000;
      end else begin
         d_q_q <= d_q_d;
      end
   end

   assign D_Q = d_q_q;

endmodule

// File: tb/tb_stopwatch_adjust_display.sv
// Directed bench for stopwatch_adjust_display: adjust outputs checked against
// a decimal-arithmetic model, display register checked through a queue.
module tb_stopwatch_adjust_display;

  localparam logic [15:0] MIN_T = 16'h1020;
  localparam logic [15:0] MAX_T = 16'h4930;

  logic        clk_in = 1'b0;
  logic        RESET = 1'b1;
  logic        ADD = 1'b0;
  logic        SUBTRACT = 1'b0;
  logic [15:0] PEV_Q = 16'h0000;
  logic [15:0] Q = 16'h0000;
  logic        ERROR_1 = 1'b0;
  logic        ERROR_2 = 1'b0;
  logic [15:0] values_from_adder;
  logic        signal;
  logic        error_signal;
  logic        error_index;
  logic [15:0] D_Q;

  logic [15:0] exp_q[$];
  logic [16:0] adj_q[$];
  int          checks = 0;
  int          failures = 0;

  stopwatch_adjust_display dut (
    .clk_in            (clk_in),
    .RESET             (RESET),
    .ADD               (ADD),
    .SUBTRACT          (SUBTRACT),
    .PEV_Q             (PEV_Q),
    .Q                 (Q),
    .ERROR_1           (ERROR_1),
    .ERROR_2           (ERROR_2),
    .values_from_adder (values_from_adder),
    .signal            (signal),
    .error_signal      (error_signal),
    .error_index       (error_index),
    .D_Q               (D_Q)
  );

  always #5 clk_in = ~clk_in;

  function automatic int bcd2int(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // Returns {signal, values_from_adder}.
  function automatic logic [16:0] adj_model(input logic [15:0] pev, input logic add, input logic sub);
    int t;
    if (add == sub) return {1'b0, pev};
    if (pev[15:12] > 9 || pev[11:8] > 9 || pev[7:4] > 5 || pev[3:0] > 9) return {1'b1, pev};
    t = bcd2int(pev);
    if (add) begin
      t = t + 100;
      if (t > 9999 || t > bcd2int(MAX_T)) return {1'b1, MAX_T};
    end else begin
      t = t - 100;
      if (t < 0 || t < bcd2int(MIN_T)) return {1'b1, MIN_T};
    end
    return {1'b0, int2bcd(t)};
  endfunction

  task automatic check_adj(input string tag, input logic [15:0] pev, input logic add,
                           input logic sub, input logic [16:0] exp);
    logic [16:0] e;
    PEV_Q = pev;
    ADD = add;
    SUBTRACT = sub;
    adj_q.push_back(exp);
    #1;
    e = adj_q.pop_front();
    checks++;
    assert ({signal, values_from_adder} === e) else begin
      failures++;
      $error("FAIL %s pev=%h observed=%h expected=%h", tag, pev, {signal, values_from_adder}, e);
    end
  endtask

  task automatic check_err(input logic e1, input logic e2, input logic [1:0] exp);
    ERROR_1 = e1;
    ERROR_2 = e2;
    #1;
    checks++;
    assert ({error_signal, error_index} === exp) else begin
      failures++;
      $error("FAIL err_flags e1=%b e2=%b observed=%b expected=%b", e1, e2, {error_signal, error_index}, exp);
    end
  endtask

  task automatic step_disp(input string tag, input logic rst, input logic [15:0] q,
                           input logic e1, input logic e2, input logic [15:0] exp);
    logic [15:0] e;
    @(negedge clk_in);
    RESET = rst;
    Q = q;
    ERROR_1 = e1;
    ERROR_2 = e2;
    exp_q.push_back(exp);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (D_Q === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, D_Q, e);
    end
  endtask

  initial begin
    logic [15:0] rp;
    logic        ra;

    step_disp("reset", 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000);

    // Adjust path, RESET still high: must not matter.
    check_adj("add_carry_min", 16'h1920, 1'b1, 1'b0, {1'b0, 16'h2020});
    check_adj("sub_borrow_min", 16'h2045, 1'b0, 1'b1, {1'b0, 16'h1945});
    RESET = 1'b0;
    check_adj("add_sat_max", 16'h4845, 1'b1, 1'b0, {1'b1, 16'h4930});
    check_adj("sub_sat_min", 16'h1110, 1'b0, 1'b1, {1'b1, 16'h1020});
    check_adj("both_pass", 16'h4930, 1'b1, 1'b1, {1'b0, 16'h4930});
    check_adj("none_pass", 16'h1234, 1'b0, 1'b0, {1'b0, 16'h1234});
    check_adj("invalid_digit", 16'h1A20, 1'b1, 1'b0, {1'b1, 16'h1A20});
    check_adj("invalid_tsec", 16'h2060, 1'b0, 1'b1, {1'b1, 16'h2060});
    check_adj("invalid_both", 16'h1A20, 1'b1, 1'b1, {1'b0, 16'h1A20});
    check_adj("add_wrap_out", 16'h9920, 1'b1, 1'b0, {1'b1, 16'h4930});
    check_adj("sub_wrap_out", 16'h0020, 1'b0, 1'b1, {1'b1, 16'h1020});
    check_adj("add_eq_max", 16'h4830, 1'b1, 1'b0, {1'b0, 16'h4930});
    check_adj("sub_eq_min", 16'h1120, 1'b0, 1'b1, {1'b0, 16'h1020});
    check_adj("add_plain", 16'h2530, 1'b1, 1'b0, {1'b0, 16'h2630});
    check_adj("sub_plain", 16'h3059, 1'b0, 1'b1, {1'b0, 16'h2959});

    for (int i = 0; i < 24; i++) begin
      rp = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      ra = 1'($urandom_range(0, 1));
      check_adj("rand_adj", rp, ra, ~ra, adj_model(rp, ra, ~ra));
    end

    check_err(1'b0, 1'b0, 2'b00);
    check_err(1'b1, 1'b0, 2'b10);
    check_err(1'b0, 1'b1, 2'b11);
    check_err(1'b1, 1'b1, 2'b10);

    // Display register.
    step_disp("disp_q", 1'b0, 16'h3215, 1'b0, 1'b0, 16'h3215);
    @(negedge clk_in);
    Q = 16'h1111;
    exp_q.push_back(16'h3215);
    #1;
    rp = exp_q.pop_front();
    checks++;
    assert (D_Q === rp) else begin
      failures++;
      $error("FAIL disp_latency observed=%h expected=%h", D_Q, rp);
    end
    step_disp("disp_err2", 1'b0, 16'h3215, 1'b0, 1'b1, 16'h5555);
    step_disp("disp_err12", 1'b0, 16'h3215, 1'b1, 1'b1, 16'hEEEE);
    step_disp("disp_clear", 1'b0, 16'h3215, 1'b0, 1'b0, 16'h3215);
    step_disp("disp_err1", 1'b0, 16'h0042, 1'b1, 1'b0, 16'hEEEE);
    step_disp("reset_prio", 1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000);
    step_disp("reset_release", 1'b0, 16'h4000, 1'b1, 1'b0, 16'hEEEE);
    step_disp("resume_q", 1'b0, 16'h4000, 1'b0, 1'b0, 16'h4000);

    for (int i = 0; i < 12; i++) begin
      rp = 16'($urandom_range(0, 65535));
      ra = 1'($urandom_range(0, 1));
      step_disp("rand_disp", 1'b0, rp, 1'b0, ra, ra ? 16'h5555 : rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
